fixed_lifting_mac: RTL and testbench
====================================

Name: fixed_lifting_mac

Overview:
- Registered signed fixed-point multiply-accumulate for the lifting steps of the 1-D recursive DWT datapath.
- Computes d = in3 + cons * (in0 + in1) in two's-complement Q(SIZE-FRAC).FRAC.
- One instance serves each lifting stage. A scale-only stage (in1 = 0, in3 = 0) reuses the same block as a plain fixed-point multiplier.

Parameters:
- SIZE, 32: width of every data operand and of the result, signed two's complement.
- FRAC, 16: number of fractional bits (Q16.16 by default). Must satisfy 0 <= FRAC < SIZE.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous reset, active-high: asserted when 1.
- in_valid  input  1  operands are sampled on this clock edge.
- in0  input  SIZE  first lifting neighbour sample.
- in1  input  SIZE  second lifting neighbour sample.
- in3  input  SIZE  accumulate (centre) sample.
- cons  input  SIZE  lifting coefficient in the same Q format (2.0 = 32'h0002_0000).
- d  output  SIZE  result register.
- out_valid  output  1  d updated on the previous edge.
- ovf  output  1  overflow occurred in the cycle that produced d.

Behaviour:
- Reset: while resetn = 1, asynchronously d = 0, out_valid = 0, ovf = 0. The first capture happens on the first rising edge after deassertion.
- Arithmetic, all signed, with no intermediate truncation:
  - sum = in0 + in1, SIZE+1 bits.
  - prod = sum * cons, 2*SIZE+1 bits.
  - scaled = prod >>> FRAC, arithmetic shift, i.e. round toward negative infinity.
  - acc = scaled + sign-extended in3.
- Result: d = acc reduced to SIZE bits, by wrap or saturation per the Optional Feature section.
- ovf = 1 when acc does not fit in signed SIZE bits.
- Latency: exactly 1 cycle.
  - in_valid = 1 at edge N: d, ovf and out_valid = 1 are visible after edge N.
  - in_valid = 0 at an edge: d and ovf hold their values; out_valid = 0.
- Throughput: one operation per cycle; back-to-back in_valid is fully supported.
- No handshake back-pressure; there is no ready signal.
- Reset asserted mid-stream: the result in flight is discarded and outputs return to 0 immediately, without waiting for a clock edge.
- Operands are don't-care when in_valid = 0, including X values; no X may propagate into d.

Optional Feature:
- Macro: FIXED_LIFTING_MAC_SATURATE_EN.
- When defined, an out-of-range acc clamps:
  - positive overflow: 2^(SIZE-1)-1 (32'h7FFF_FFFF).
  - negative overflow: -2^(SIZE-1) (32'h8000_0000).
- When undefined, d takes the low SIZE bits of acc (wrap-around).
- ovf behaves identically in both builds.

Decomposition:
- Package dwt_fixed_pkg holds:
  - SIZE_DEFAULT and FRAC_DEFAULT.
  - ONE_Q constant (1 << FRAC).
  - Lifting coefficients ALPHA_Q, BETA_Q, GAMMA_Q, DELTA_Q, ZETA_Q (2.0, 3.0, 4.0, 5.0, 6.0 in Q16.16).
  - Typedef fixed_t, signed [SIZE-1:0].
- One sub-module: fixed_point_multiplier. It is combinational and computes (a*b)>>>FRAC at full width with an overflow flag.
- fixed_lifting_mac contains the pre-adder, the accumulate, the saturate/wrap logic and the output register.

Test Plan:
- Basic MAC: in0 = 32'h0001_0000, in1 = 0, in3 = 32'h0000_8000, cons = 32'h0002_0000 -> d = 32'h0002_8000 one cycle later; out_valid = 1; ovf = 0.
- Negative and pre-add: in0 = 32'hFFFF_0000, in1 = 32'hFFFF_0000, in3 = 0, cons = 32'h0003_0000 -> d = 32'hFFFA_0000 (-6.0).
- Rounding floor: cons = 32'h0000_8000, in1 = in3 = 0.
  - in0 = 32'h0000_0001 -> d = 0.
  - in0 = 32'hFFFF_FFFF -> d = 32'hFFFF_FFFF.
- Overflow: in0 = 32'h7FFF_0000, in1 = 0, in3 = 0, cons = 32'h0002_0000 -> ovf = 1.
  - With FIXED_LIFTING_MAC_SATURATE_EN: d = 32'h7FFF_FFFF.
  - Without it: d = 32'hFFFE_0000.
- Streaming/hold: 4 back-to-back valid operations, then in_valid = 0 for 3 cycles -> each result appears 1 cycle after its inputs; d then holds the last result with out_valid = 0.
- Async reset: assert resetn between clock edges during streaming -> d, out_valid and ovf go to 0 before the next edge. After release, the first valid operation completes with 1-cycle latency.

Source files
------------

// File: rtl/dwt_fixed_pkg.sv
// dwt_fixed_pkg: shared fixed-point widths, lifting coefficients and data type for the DWT datapath
package dwt_fixed_pkg;
    localparam int SIZE_DEFAULT = 32;
    localparam int FRAC_DEFAULT = 16;
    localparam int ONE_Q = 1 << FRAC_DEFAULT;
    localparam logic signed [SIZE_DEFAULT-1:0] ALPHA_Q = 32'sh0002_0000;
    localparam logic signed [SIZE_DEFAULT-1:0] BETA_Q  = 32'sh0003_0000;
    localparam logic signed [SIZE_DEFAULT-1:0] GAMMA_Q = 32'sh0004_0000;
    localparam logic signed [SIZE_DEFAULT-1:0] DELTA_Q = 32'sh0005_0000;
    localparam logic signed [SIZE_DEFAULT-1:0] ZETA_Q  = 32'sh0006_0000;
    typedef logic signed [SIZE_DEFAULT-1:0] fixed_t;
endpackage

// File: rtl/fixed_point_multiplier.sv
// fixed_point_multiplier: combinational full-width (a*b)>>>FRAC, result truncated to OW bits with overflow flag
module fixed_point_multiplier #(
    parameter int AW = 33,
    parameter int BW = 32,
    parameter int FRAC = 16,
    parameter int OW = 33
) (
    input  logic signed [AW-1:0] a,
    input  logic signed [BW-1:0] b,
    output logic signed [OW-1:0] p,
    output logic                 ovf
);
    localparam int W = AW + BW;
    logic signed [W-1:0] full;
    assign full = (a * b) >>> FRAC;
    assign p = full[OW-1:0];
    assign ovf = ~((&full[W-1:OW-1]) | ~(|full[W-1:OW-1]));
endmodule

// File: rtl/fixed_lifting_mac.sv
// fixed_lifting_mac: registered d = in3 + cons*(in0+in1) in signed fixed point, one-cycle latency.
// Define FIXED_LIFTING_MAC_SATURATE_EN to clamp out-of-range results instead of wrapping.
module fixed_lifting_mac
    import dwt_fixed_pkg::*;
#(
    parameter int SIZE = SIZE_DEFAULT,
    parameter int FRAC = FRAC_DEFAULT
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    input  logic [SIZE-1:0] in0,
    input  logic [SIZE-1:0] in1,
    input  logic [SIZE-1:0] in3,
    input  logic [SIZE-1:0] cons,
    output logic [SIZE-1:0] d,
    output logic            out_valid,
    output logic            ovf
);
    logic signed [SIZE:0]   sum;
    logic signed [SIZE:0]   scaled;
    logic signed [SIZE+1:0] acc;
    logic                   mul_ovf;
    logic                   ovf_n;
    logic [SIZE-1:0]        d_n;
    assign sum = $signed(in0) + $signed(in1);
    // A scaled value outside SIZE+1 bits can never be pulled back into range by in3
    fixed_point_multiplier #(.AW(SIZE + 1), .BW(SIZE), .FRAC(FRAC), .OW(SIZE + 1)) u_mul (
        .a(sum),
        .b($signed(cons)),
        .p(scaled),
        .ovf(mul_ovf)
    );
    assign acc = scaled + $signed(in3);
    assign ovf_n = mul_ovf | ~((&acc[SIZE+1:SIZE-1]) | ~(|acc[SIZE+1:SIZE-1]));
`ifdef FIXED_LIFTING_MAC_SATURATE_EN
    logic neg;
    assign neg = mul_ovf ? sum[SIZE] ^ cons[SIZE-1] : acc[SIZE+1];
    assign d_n = ovf_n ? (neg ? {1'b1, {(SIZE-1){1'b0}}} : {1'b0, {(SIZE-1){1'b1}}}) : acc[SIZE-1:0];
`else
    assign d_n = acc[SIZE-1:0];
`endif
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            d <= '0;
            out_valid <= 1'b0;
            ovf <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                d <= d_n;
                ovf <= ovf_n;
            end
        end
    end
endmodule

// File: tb/tb_fixed_lifting_mac.sv
// tb_fixed_lifting_mac: directed vectors and corner sequences for fixed_lifting_mac (wrap or saturate build)
module tb_fixed_lifting_mac;
    import dwt_fixed_pkg::*;
    logic clk = 1'b0;
    logic resetn, in_valid, out_valid, ovf;
    logic [31:0] in0, in1, in3, cons, d;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] in0, in1, in3, cons, dw, ds;
        logic ovf;
    } vec_t;
    vec_t v[10];

    fixed_lifting_mac dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid),
        .in0(in0), .in1(in1), .in3(in3), .cons(cons),
        .d(d), .out_valid(out_valid), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    function automatic logic [31:0] exp_d(input vec_t x);
`ifdef FIXED_LIFTING_MAC_SATURATE_EN
        return x.ds;
`else
        return x.dw;
`endif
    endfunction

    task automatic drive(input vec_t x);
        in_valid = 1'b1;
        in0 = x.in0;
        in1 = x.in1;
        in3 = x.in3;
        cons = x.cons;
    endtask

    initial begin
        v[0] = '{32'h0001_0000, 32'h0, 32'h0000_8000, ALPHA_Q, 32'h0002_8000, 32'h0002_8000, 1'b0};
        v[1] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'h0, BETA_Q, 32'hFFFA_0000, 32'hFFFA_0000, 1'b0};
        v[2] = '{32'h0000_0001, 32'h0, 32'h0, 32'h0000_8000, 32'h0, 32'h0, 1'b0};
        v[3] = '{32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0000_8000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        v[4] = '{32'h7FFF_0000, 32'h0, 32'h0, 32'h0002_0000, 32'hFFFE_0000, 32'h7FFF_FFFF, 1'b1};
        v[5] = '{32'h7FFF_0000, 32'h7FFF_0000, 32'h0, 32'h7FFF_0000, 32'h0002_0000, 32'h7FFF_FFFF, 1'b1};
        v[6] = '{32'h8000_0000, 32'h8000_0000, 32'h0, 32'h7FFF_0000, 32'h0, 32'h8000_0000, 1'b1};
        v[7] = '{32'h8000_0000, 32'h0, 32'h8000_0000, 32'h0001_0000, 32'h0, 32'h8000_0000, 1'b1};
        v[8] = '{32'h7FFF_0000, 32'h0, 32'h8000_0000, 32'h0002_0000, 32'h7FFE_0000, 32'h7FFE_0000, 1'b0};
        v[9] = '{32'h0001_8000, 32'h0, 32'h0, ZETA_Q, 32'h0009_0000, 32'h0009_0000, 1'b0};

        resetn = 1'b0;
        in_valid = 1'b0;
        {in0, in1, in3, cons} = '0;
        #1 resetn = 1'b1;
        #2;
        chk("reset_d", d, 32'h0);
        chk("reset_out_valid", {31'b0, out_valid}, 32'h0);
        chk("reset_ovf", {31'b0, ovf}, 32'h0);
        @(negedge clk) resetn = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk) drive(v[i]);
            @(posedge clk) #1;
            chk($sformatf("vec%0d_d", i), d, exp_d(v[i]));
            chk($sformatf("vec%0d_ovf", i), {31'b0, ovf}, {31'b0, v[i].ovf});
            chk($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, 32'h1);
        end

        for (int k = 1; k <= 3; k++) begin
            @(negedge clk) drive('{k * ONE_Q, 32'h0, 32'h100, ONE_Q, 32'h0, 32'h0, 1'b0});
            @(posedge clk) #1;
            chk($sformatf("stream%0d_d", k), d, k * ONE_Q + 32'h100);
            chk($sformatf("stream%0d_out_valid", k), {31'b0, out_valid}, 32'h1);
        end
        @(negedge clk) drive(v[4]);
        @(posedge clk) #1;
        chk("stream4_d", d, exp_d(v[4]));
        chk("stream4_ovf", {31'b0, ovf}, 32'h1);
        @(negedge clk) begin
            in_valid = 1'b0;
            {in0, in1, in3, cons} = 'x;
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk) #1;
            chk($sformatf("hold%0d_d", k), d, exp_d(v[4]));
            chk($sformatf("hold%0d_ovf", k), {31'b0, ovf}, 32'h1);
            chk($sformatf("hold%0d_out_valid", k), {31'b0, out_valid}, 32'h0);
        end

        @(negedge clk) drive(v[4]);
        @(posedge clk) #1;
        chk("pre_reset_ovf", {31'b0, ovf}, 32'h1);
        #2 resetn = 1'b1;
        #1;
        chk("async_reset_d", d, 32'h0);
        chk("async_reset_out_valid", {31'b0, out_valid}, 32'h0);
        chk("async_reset_ovf", {31'b0, ovf}, 32'h0);
        @(posedge clk) #1;
        chk("held_reset_d", d, 32'h0);
        chk("held_reset_out_valid", {31'b0, out_valid}, 32'h0);
        @(negedge clk) begin
            resetn = 1'b0;
            drive(v[0]);
        end
        @(posedge clk) #1;
        chk("post_reset_d", d, exp_d(v[0]));
        chk("post_reset_out_valid", {31'b0, out_valid}, 32'h1);

        @(negedge clk) begin
            in_valid = 1'b0;
            {in0, in1, in3, cons} = 'x;
        end
        @(posedge clk) #1;
        chk("x_idle_d", d, exp_d(v[0]));
        chk("x_idle_ovf", {31'b0, ovf}, 32'h0);
        chk("x_idle_out_valid", {31'b0, out_valid}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
